flag_stuff_tx: RTL and testbench

- Serial frame transmitter. It is the sending end of the "111" sequence-detector link.
- Each accepted parallel word goes out on the single-bit line x as one frame:
  - a 3-bit flag "111",
  - a separator 0,
  - the data bits MSB-first, with zero-stuffing,
  - a trailing 0.
- Zero-stuffing: a 0 is inserted after every two consecutive data 1s. This guarantees a downstream 111 detector fires exactly once per frame, on the flag only.
- Used as the stimulus source for the detector FSM and in loopback benches.

---
 rtl/flag_stuff_tx.sv | 177 +++++++++++++++++
 tb/tb_flag_stuff_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/flag_stuff_tx.sv
// -----------------------------------------------------------------------------
// flag_stuff_tx
//   Serial frame transmitter for the "111" sequence-detector link. Each accepted
//   word is sent on x as: flag 1,1,1 / separator 0 / data MSB-first with a 0
//   stuffed after every two consecutive data 1s (unless no data bit remains) /
//   trailing 0. Stuffing keeps "111" on the line unique to the flag.
//
// Ports
//   clk    in   1      system clock, rising edge
//   reset  in   1      asynchronous active-high reset
//   start  in   1      send request, sampled only while idle
//   data   in   WIDTH  word to send, captured on the accepting edge
//   x      out  1      serial line (registered)
//   busy   out  1      high from the accepting edge through the tail bit
//   done   out  1      one-cycle pulse after a frame completes
// -----------------------------------------------------------------------------
module flag_stuff_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             x,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // The state names what is on x during the current cycle.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLAG  = 3'd1;
  localparam logic [2:0] S_SEP   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STUFF = 3'd4;
  localparam logic [2:0] S_TAIL  = 3'd5;

  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(WIDTH);

  logic [2:0]       state_q,    state_d;
  logic [WIDTH-1:0] shreg_q,    shreg_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [1:0]       flag_cnt_q, flag_cnt_d;
  logic [1:0]       ones_q,     ones_d;
  logic             x_q,        x_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  // Shift register after emitting its MSB.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0};
  endfunction

  // Next-state and next-output logic; outputs move together with the state.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    flag_cnt_d = flag_cnt_q;
    ones_d     = ones_q;
    x_d        = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FLAG;
          shreg_d    = data;
          bit_cnt_d  = '0;
          flag_cnt_d = 2'd1;
          ones_d     = 2'd0;
          x_d        = 1'b1;
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end

      S_FLAG: begin
        // flag_cnt counts flag bits already on the line.
        if (flag_cnt_q == 2'd3) begin
          state_d    = S_SEP;
          flag_cnt_d = 2'd0;
          x_d        = 1'b0;
        end else begin
          flag_cnt_d = flag_cnt_q + 2'd1;
          x_d        = 1'b1;
        end
      end

      S_SEP: begin
        // First data bit; the ones run starts fresh.
        state_d   = S_DATA;
        x_d       = shreg_q[WIDTH-1];
        shreg_d   = shift_out(shreg_q);
        bit_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        ones_d    = {1'b0, shreg_q[WIDTH-1]};
      end

      S_DATA: begin
        // Tail check comes first: a run of two on the last bit needs no stuff.
        if (bit_cnt_q == BITS_LAST) begin
          state_d = S_TAIL;
          x_d     = 1'b0;
        end else if (ones_q == 2'd2) begin
          state_d = S_STUFF;
          x_d     = 1'b0;
          ones_d  = 2'd0;
        end else begin
          x_d       = shreg_q[WIDTH-1];
          shreg_d   = shift_out(shreg_q);
          bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          ones_d    = shreg_q[WIDTH-1] ? (ones_q + 2'd1) : 2'd0;
        end
      end

      S_STUFF: begin
        // Run was cleared by the stuffed zero, so the new run is just this bit.
        state_d   = S_DATA;
        x_d       = shreg_q[WIDTH-1];
        shreg_d   = shift_out(shreg_q);
        bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        ones_d    = {1'b0, shreg_q[WIDTH-1]};
      end

      S_TAIL: begin
        state_d   = S_IDLE;
        x_d       = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        bit_cnt_d = '0;
        ones_d    = 2'd0;
      end

      default: begin
        state_d    = S_IDLE;
        shreg_d    = '0;
        bit_cnt_d  = '0;
        flag_cnt_d = 2'd0;
        ones_d     = 2'd0;
        x_d        = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      flag_cnt_q <= 2'd0;
      ones_q     <= 2'd0;
      x_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      flag_cnt_q <= flag_cnt_d;
      ones_q     <= ones_d;
      x_q        <= x_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign x    = x_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_flag_stuff_tx.sv
// -----------------------------------------------------------------------------
// tb_flag_stuff_tx
//   Self-checking bench for flag_stuff_tx (WIDTH=8). A reference model builds
//   the expected bit stream of each frame from the framing rules; a simple
//   "111" detector on the sampled line checks the flag is the only match.
// -----------------------------------------------------------------------------
module tb_flag_stuff_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic       x;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;

  logic [2:0] hist;
  logic       det;
  bit         exp_q[$];

  flag_stuff_tx #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .x     (x),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame: flag, separator, stuffed data, tail.
  task automatic build_frame(input logic [7:0] d);
    int run;
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    run = 0;
    for (int j = 7; j >= 0; j--) begin
      exp_q.push_back(d[j]);
      run = d[j] ? run + 1 : 0;
      if (run == 2 && j > 0) begin
        exp_q.push_back(1'b0);
        run = 0;
      end
    end
    exp_q.push_back(1'b0);
  endtask

  // Advance to the next falling edge and feed the line detector.
  task automatic sample();
    @(negedge clk);
    hist = {hist[1:0], x};
    det  = (hist == 3'b111);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      chk("idle_x", x, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
    end
  endtask

  // Send one frame from an idle (or done-pulse) cycle and check it bit by bit,
  // ending on the done-pulse cycle.
  task automatic send_frame(input logic [7:0] d, input bit glitch,
                            output logic [31:0] xbits, output int blen);
    int n;
    build_frame(d);
    n     = exp_q.size();
    xbits = 32'd0;
    blen  = 0;
    start = 1'b1;
    data  = d;
    for (int i = 0; i < n; i++) begin
      sample();
      chk("frame_x", x, exp_q[i]);
      chk("frame_busy", busy, 1'b1);
      chk("frame_done", done, 1'b0);
      chk("frame_det", det, (i == 2) ? 1'b1 : 1'b0);
      xbits = {xbits[30:0], x};
      if (busy) blen++;
      // Data wanders during the frame; optionally re-request mid-frame.
      data  = 8'($urandom);
      start = (glitch && i >= 4 && i <= 6 && i < n - 1) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    sample();
    chk("end_x", x, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("end_done", done, 1'b1);
    chk("end_det", det, 1'b0);
  endtask

  initial begin
    logic [31:0] xb;
    int          bl;
    n_checks = 0;
    n_fail   = 0;
    hist     = 3'b000;
    det      = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    data     = 8'h00;

    // Reset state.
    sample();
    chk("rst_x", x, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    idle_cycles(2);

    // Directed frames with literal expected waveforms.
    send_frame(8'h00, 1'b0, xb, bl);
    chk("d00_bits", xb, 32'h0000_1C00);
    chk("d00_len", bl, 32'd13);
    idle_cycles(2);

    send_frame(8'hFF, 1'b0, xb, bl);
    chk("dFF_bits", xb, 32'h0000_EDB6);
    chk("dFF_len", bl, 32'd16);
    idle_cycles(1);

    send_frame(8'hB6, 1'b0, xb, bl);
    chk("dB6_bits", xb, 32'h0000_7598);
    chk("dB6_len", bl, 32'd15);
    idle_cycles(1);

    // Mid-frame start with other data is ignored.
    send_frame(8'h5A, 1'b1, xb, bl);
    idle_cycles(2);

    // Asynchronous reset in the middle of the data field.
    build_frame(8'hFF);
    start = 1'b1;
    data  = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      sample();
      start = 1'b0;
      chk("pre_rst_x", x, exp_q[i]);
    end
    #2 reset = 1'b1;
    #1;
    chk("arst_x", x, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    hist = 3'b000;
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(2);
    send_frame(8'hB6, 1'b0, xb, bl);
    chk("post_rst_bits", xb, 32'h0000_7598);
    idle_cycles(1);

    // Loopback sweep of every value, back-to-back.
    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), 1'b0, xb, bl);
    end
    idle_cycles(1);

    // Random frames, random gaps, random mid-frame requests.
    for (int r = 0; r < 60; r++) begin
      send_frame(8'($urandom), bit'($urandom_range(0, 1)), xb, bl);
      idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
